if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end. Drives sequential PCs to the instruction ROM over a request/grant/response handshake.
- Buffers returned words, each paired with its PC, in a small FIFO.
- Presents {pc, inst} to the decode stage under a valid/ready handshake.
- Supports a one-cycle redirect (flush) from branch resolution, discarding every in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rom_req_o  out  1  fetch request.
- rom_addr_o  out  32  fetch address; word aligned.
- rom_gnt_i  in  1  request accepted this cycle.
- rom_rvalid_i  in  1  response data valid; in order, at least 1 cycle after grant.
- rom_rdata_i  in  32  instruction word.
- flush_i  in  1  redirect strobe, single cycle.
- flush_pc_i  in  32  redirect target.
- id_ready_i  in  1  decode accepts this cycle (low = stall).
- if_valid_o  out  1  if_pc_o / if_inst_o valid.
- if_pc_o  out  32  PC of the presented instruction.
- if_inst_o  out  32  presented instruction.

Behaviour:
- Reset state (rst=0, asynchronous):
  - fetch_pc = resp_pc = RESET_PC.
  - count, outstanding and discard = 0.
  - rom_req_o = 0, if_valid_o = 0, if_pc_o = 0, if_inst_o = 0.
- Request rule:
  - rom_req_o = !flush_i && (count + outstanding < BUF_DEPTH).
  - rom_addr_o = fetch_pc.
- Grant: when rom_req_o && rom_gnt_i, fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Address stability: while rom_req_o is high and not granted, rom_addr_o is held stable.
- Response (rom_rvalid_i), outstanding decrements:
  - If discard != 0: drop the data, discard -= 1.
  - Else: push {resp_pc, rom_rdata_i} and resp_pc += 4.
- Protocol error: rom_rvalid_i with outstanding == 0 is ignored, with no state change; the bench flags it.
- Pop: if_valid_o && id_ready_i removes the head entry.
  - Push and pop in the same cycle leave count unchanged.
  - Credit accounting guarantees no push when full; the sim assertion is "no push at count == BUF_DEPTH without a pop".
- Output path:
  - if_valid_o = (count != 0) && !flush_i.
  - if_pc_o / if_inst_o = head entry, or 0 when count == 0.
  - Head is driven from registered FIFO state (no response-to-output bypass).
- Latency: grant in cycle N and rvalid in N+1 give if_valid_o in N+2. With 1-cycle ROM latency and BUF_DEPTH >= 4, throughput is one instruction per cycle.
- Flush cycle (flush_i = 1):
  - FIFO emptied (count = 0); any pop that cycle is ignored.
  - fetch_pc = resp_pc = flush_pc_i.
  - discard = outstanding after this cycle's response decrement, so every pre-flush request is dropped.
  - rom_req_o forced 0, so there is no grant that cycle.
  - Requests resume next cycle from flush_pc_i; their responses are kept once discard reaches 0.
- Flush while discard != 0: discard recomputed as above; there is no double counting because each response decrements outstanding exactly once.
- Back-to-back flushes: the last one wins.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset release with outstanding == 0 are ignored.
- Stall: id_ready_i low holds the head stable. The FIFO fills, then rom_req_o drops once the credit limit is hit.

Decomposition:
- defines.v (shared):
  - Existing `InstAddrBus`, `InstBus`, `ZeroWord`.
  - New `RstnEnable` 1'b0 / `RstnDisable` 1'b1 for the active-low reset.
  - New `IfBufWidth` 64 ({pc, inst}).
- Sub-module if_buf: synchronous FIFO, BUF_DEPTH entries × 64 bits.
  - Ports: push, pop, clear, din, dout, count; same clk and rst.
  - Pointer wrap modulo BUF_DEPTH.
- Credit, discard, PC counters and the handshake stay in if_fetch.

Test Plan:
- Reset release, 1-cycle ROM returning addr^32'hA5A5_0000, id_ready_i = 1:
  - rom_addr_o sequence is 0, 4, 8, ….
  - First if_valid_o 2 cycles after the first grant, pc=0, inst=32'hA5A5_0000.
  - Then one instruction per cycle.
- id_ready_i = 0 for 10 cycles:
  - count saturates at 4 and rom_req_o goes low once count + outstanding = 4.
  - Head stays pc=0.
  - On release, pcs 0..12 delivered in order with no gaps or duplicates.
- ROM with 3-cycle latency, 2 requests in flight, flush_i with flush_pc_i = 32'h100:
  - Both stale responses dropped.
  - Next delivered pc = 32'h100 with inst 32'hA5A5_0100.
- rom_gnt_i held low for 5 cycles: rom_addr_o stable at the ungranted address and no fetch_pc advance.
- Flush in the same cycle as a response and a pop with count = 2:
  - FIFO empties, the response is dropped, and discard = remaining outstanding.
  - if_valid_o = 0 that cycle.
- rst pulsed low mid-stream for 1 cycle:
  - All outputs 0 asynchronously.
  - Refetch starts at RESET_PC.
  - A stray rom_rvalid_i after release is ignored.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, reset levels and the {pc, inst} entry type used by the
// instruction-fetch front end and its buffer.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int IF_BUF_W    = INST_ADDR_W + INST_W;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic                   RSTN_ENABLE  = 1'b0;
  localparam logic                   RSTN_DISABLE = 1'b1;
  localparam logic [INST_ADDR_W-1:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } if_entry_t;

  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_buf.sv
// Synchronous FIFO of {pc, inst} entries between the ROM response path and
// decode; head is read straight from the registered storage.
module if_buf
  import if_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  localparam int PTR_W = $clog2(BUF_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  if_entry_t        din,
  output if_entry_t        dout,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  if_entry_t        mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : if_entry_t'({ZERO_WORD, ZERO_WORD});

  a_no_overflow: assert property (@(posedge clk) disable iff (rst == RSTN_ENABLE)
    !(push && !clear && !do_pop && (count == FULL)));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: credit-limited sequential ROM requests, in-order
// response buffering and a single-cycle redirect that drops stale responses.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                     BUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_req_o,
  output logic [INST_ADDR_W-1:0] rom_addr_o,
  input  logic                   rom_gnt_i,
  input  logic                   rom_rvalid_i,
  input  logic [INST_W-1:0]      rom_rdata_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] flush_pc_i,
  input  logic                   id_ready_i,
  output logic                   if_valid_o,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(BUF_DEPTH);

  logic [INST_ADDR_W-1:0] fetch_pc;
  logic [INST_ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       discard;
  logic [CNT_W:0]         credit_used;
  logic                   grant;
  logic                   resp_ok;
  logic                   push;
  logic                   pop;
  if_entry_t              din;
  if_entry_t              head;

  // Buffered plus in-flight words may never exceed the buffer, so every
  // response always has a slot waiting for it.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign rom_req_o   = (rst == RSTN_DISABLE) && !flush_i && (credit_used < CREDITS);
  assign rom_addr_o  = fetch_pc;
  assign grant       = rom_req_o && rom_gnt_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok = rom_rvalid_i && (outstanding != '0);
  assign push    = resp_ok && (discard == '0) && !flush_i;
  assign pop     = if_valid_o && id_ready_i;
  assign din     = {resp_pc, rom_rdata_i};

  assign if_valid_o = (count != '0) && !flush_i;
  assign if_pc_o    = head.pc;
  assign if_inst_o  = head.inst;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(resp_ok);
      if (flush_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= flush_pc_i;
        resp_pc  <= flush_pc_i;
        discard  <= outstanding - CNT_W'(resp_ok);
      end else begin
        if (grant) fetch_pc <= next_pc(fetch_pc);
        if (push)  resp_pc  <= next_pc(resp_pc);
        if (resp_ok && (discard != '0)) discard <= discard - CNT_W'(1);
      end
    end
  end

  if_buf #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .clear(flush_i),
    .din  (din),
    .dout (head),
    .count(count)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch against a queue-based model of requests,
// in-flight responses and the decode buffer, plus directed scenarios.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_gnt_i   (rom_gnt_i),
    .rom_rvalid_i(rom_rvalid_i),
    .rom_rdata_i (rom_rdata_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .id_ready_i  (id_ready_i),
    .if_valid_o  (if_valid_o),
    .if_pc_o     (if_pc_o),
    .if_inst_o   (if_inst_o)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } rom_t;
  typedef struct { logic [31:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  rom_t rom_q[$];
  req_t inflight[$];
  ent_t fifo[$];
  logic [31:0] m_fetch_pc;

  int cyc, passed, total;

  bit          gnt_rand, ready_rand, flush_set, stray_set;
  logic        gnt_set, ready_set;
  logic [31:0] flush_pc_set;
  int          lat_min, lat_max;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  task automatic model_clear();
    fifo.delete();
    inflight.delete();
    rom_q.delete();
    m_fetch_pc = RESET_PC;
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, compare, advance model.
  task automatic cycle();
    bit          e_req, e_valid, do_pop;
    logic [31:0] e_pc, e_inst;
    req_t        r;
    rom_t        rr;
    @(posedge clk);
    #1;
    cyc++;
    flush_i    = flush_set;
    flush_pc_i = flush_pc_set;
    id_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_set;
    rom_gnt_i  = gnt_rand ? ($urandom_range(0, 2) != 0) : gnt_set;
    if (stray_set) begin
      rom_rvalid_i = 1'b1;
      rom_rdata_i  = 32'hDEAD_BEEF;
    end else if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
      rom_rvalid_i = 1'b1;
      rom_rdata_i  = rom_q[0].data;
      rom_q.delete(0);
    end else begin
      rom_rvalid_i = 1'b0;
      rom_rdata_i  = $urandom();
    end
    #2;
    s_req = rom_req_o; s_addr = rom_addr_o;
    s_valid = if_valid_o; s_pc = if_pc_o; s_inst = if_inst_o;

    e_req   = !flush_i && (fifo.size() + inflight.size() < DEPTH);
    e_valid = (fifo.size() != 0) && !flush_i;
    e_pc    = (fifo.size() != 0) ? fifo[0].pc : 32'h0;
    e_inst  = (fifo.size() != 0) ? fifo[0].inst : 32'h0;
    chk("req", 32'(s_req), 32'(e_req));
    chk("addr", s_addr, m_fetch_pc);
    chk("valid", 32'(s_valid), 32'(e_valid));
    chk("pc", s_pc, e_pc);
    chk("inst", s_inst, e_inst);

    if (s_req && rom_gnt_i) begin
      rr.addr = s_addr;
      rr.data = s_addr ^ XOR_KEY;
      rr.due  = cyc + int'($urandom_range(lat_max, lat_min));
      rom_q.push_back(rr);
    end

    do_pop = e_valid && id_ready_i;
    if (do_pop) fifo.delete(0);
    if (rom_rvalid_i && inflight.size() > 0) begin
      r = inflight[0];
      inflight.delete(0);
      if (!r.stale && !flush_i) fifo.push_back('{r.pc, rom_rdata_i});
    end
    if (e_req && rom_gnt_i) begin
      inflight.push_back('{m_fetch_pc, 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (flush_i) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fifo.delete();
      m_fetch_pc = flush_pc_i;
    end
    flush_set = 1'b0;
    stray_set = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(rom_req_o), 32'd0);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_addr", rom_addr_o, RESET_PC);
    model_clear();
    flush_i = 1'b0; rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle();
      if (s_valid) seen = 1'b1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_pc"}, s_pc, exp_pc);
      chk({name, "_inst"}, s_inst, exp_pc ^ XOR_KEY);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    cyc = 0; passed = 0; total = 0;
    rst = 1'b0; flush_i = 1'b0; flush_pc_i = '0; id_ready_i = 1'b1;
    rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = '0;
    gnt_rand = 0; ready_rand = 0; flush_set = 0; stray_set = 0;
    gnt_set = 1'b1; ready_set = 1'b1; flush_pc_set = '0;
    lat_min = 1; lat_max = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_req", 32'(rom_req_o), 32'd0);
    chk("init_valid", 32'(if_valid_o), 32'd0);
    chk("init_pc", if_pc_o, 32'd0);
    chk("init_inst", if_inst_o, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;

    // 1-cycle ROM, decode always ready: full throughput.
    cycle(); chk("t1_addr0", s_addr, 32'h0); chk("t1_req0", 32'(s_req), 32'd1);
    cycle(); chk("t1_addr1", s_addr, 32'h4); chk("t1_nv", 32'(s_valid), 32'd0);
    cycle(); chk("t1_v", 32'(s_valid), 32'd1); chk("t1_pc0", s_pc, 32'h0);
    chk("t1_inst0", s_inst, 32'hA5A5_0000); chk("t1_addr2", s_addr, 32'h8);
    cycle(); chk("t1_pc1", s_pc, 32'h4); chk("t1_inst1", s_inst, 32'hA5A5_0004);
    repeat (12) cycle();

    // Decode stall fills the buffer, then releases in order.
    pulse_reset();
    ready_set = 1'b0;
    repeat (10) cycle();
    chk("t2_req_off", 32'(s_req), 32'd0);
    chk("t2_head_v", 32'(s_valid), 32'd1);
    chk("t2_head_pc", s_pc, 32'h0);
    ready_set = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_valid && id_ready_i) got.push_back(s_pc);
    end
    chk("t2_count", 32'(got.size() >= 4), 32'd1);
    if (got.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t2_order", got[i], 32'(i * 4));

    // 3-cycle ROM, two stale requests in flight at the redirect.
    pulse_reset();
    lat_min = 3; lat_max = 3;
    cycle(); cycle();
    gnt_set = 1'b0; flush_set = 1'b1; flush_pc_set = 32'h100;
    cycle();
    chk("t3_req_flush", 32'(s_req), 32'd0);
    gnt_set = 1'b1;
    wait_valid("t3", 32'h100, 20);

    // Grant withheld: address holds at the ungranted PC.
    pulse_reset();
    lat_min = 1; lat_max = 1; gnt_set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_addr_hold", s_addr, RESET_PC);
      chk("t4_req_hold", 32'(s_req), 32'd1);
    end
    gnt_set = 1'b1;
    cycle(); chk("t4_addr_g", s_addr, RESET_PC);
    cycle(); chk("t4_addr_n", s_addr, RESET_PC + 32'd4);

    // Flush coinciding with a response and a pop at count 2.
    pulse_reset();
    lat_min = 2; lat_max = 2; ready_set = 1'b0;
    repeat (4) cycle();
    ready_set = 1'b1; flush_set = 1'b1; flush_pc_set = 32'h200;
    cycle();
    chk("t5_rvalid", 32'(rom_rvalid_i), 32'd1);
    chk("t5_valid", 32'(s_valid), 32'd0);
    chk("t5_req", 32'(s_req), 32'd0);
    wait_valid("t5", 32'h200, 20);

    // Reset mid-stream, then a stray response with nothing outstanding.
    ready_rand = 1; gnt_rand = 1; lat_min = 1; lat_max = 3;
    repeat (30) cycle();
    pulse_reset();
    ready_rand = 0; gnt_rand = 0; ready_set = 1'b1; gnt_set = 1'b1;
    lat_min = 1; lat_max = 1; stray_set = 1'b1;
    wait_valid("t6", RESET_PC, 10);

    // Random traffic with redirects (including back-to-back and wrap).
    ready_rand = 1; gnt_rand = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) pulse_reset();
      if ($urandom_range(0, 29) == 0 || i == 700 || i == 701) begin
        flush_set = 1'b1;
        flush_pc_set = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
